// File: rtl/count_wrap_monitor_pkg.sv
// Shared encodings and widths for the count wrap monitor and its event FIFO.
package count_mon_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic {
        EVT_WRAP = 1'b0,
        EVT_ERR  = 1'b1
    } evt_type_e;

    // Event record layout: {type, epoch, count}.
    function automatic int rec_w(input int epoch_w);
        return epoch_w + COUNT_W + 1;
    endfunction

endpackage

// File: rtl/count_wrap_monitor_if.sv
// Valid/ready event stream carrying {type, epoch, count} records out of the monitor.
interface count_wrap_monitor_if
    import count_mon_pkg::*;
#(
    parameter int EPOCH_W = 8
) ();

    logic                        evt_valid;
    logic                        evt_ready;
    logic [rec_w(EPOCH_W)-1:0]   evt_data;

    modport master (output evt_valid, output evt_data, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_data, output evt_ready);

endinterface

// File: rtl/count_evt_fifo.sv
// Small synchronous FIFO with valid/ready read side; a push while full is accepted only with a same-cycle pop.
module count_evt_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             wr;

    assign rd_valid = (level != '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    assign wr       = push && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; rd_data is gated by rd_valid so stale entries never reach the output.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// Watches a 4-bit down counter, counts 0->15 wraps into an epoch and queues wrap/error records.
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int EPOCH_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [COUNT_W-1:0]              count,
    input  logic                            clr_flags,
    output logic                            wrap_pulse,
    output logic                            err_pulse,
    output logic [EPOCH_W-1:0]              epoch,
    output logic                            epoch_ovf,
    output logic                            drop_flag,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    count_wrap_monitor_if.master            evt
);

    localparam int REC_W = rec_w(EPOCH_W);

    logic [COUNT_W-1:0] prev_cnt;
    logic [COUNT_W-1:0] expected;
    logic               prev_vld;
    logic               check_en;
    logic               is_wrap;
    logic               is_err;
    logic               push;
    logic               pop;
    logic               full;
    logic               drop_set;
    logic               ovf_set;
    logic [EPOCH_W-1:0] epoch_next;
    evt_type_e          evt_type;
    logic [REC_W-1:0]   rec;

    // A down counter steps to prev-1; 0->15 is that same legal step and marks a wrap.
    assign expected   = prev_cnt - 1'b1;
    assign check_en   = en && prev_vld;
    assign is_err     = check_en && (count != expected);
    assign is_wrap    = check_en && (prev_cnt == '0) && (count == '1);
    assign epoch_next = is_wrap ? epoch + 1'b1 : epoch;
    assign evt_type   = is_err ? EVT_ERR : EVT_WRAP;
    assign rec        = {evt_type, epoch_next, count};
    assign push       = is_wrap || is_err;
    assign pop        = evt.evt_valid && evt.evt_ready;
    assign drop_set   = push && full && !pop;
    assign ovf_set    = is_wrap && (epoch == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cnt   <= '0;
            prev_vld   <= 1'b0;
            epoch      <= '0;
            epoch_ovf  <= 1'b0;
            drop_flag  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            if (en) prev_cnt <= count;
            prev_vld   <= en;
            epoch      <= epoch_next;
            wrap_pulse <= is_wrap;
            err_pulse  <= is_err;
            // Setting outranks a simultaneous clear so no event is ever lost from the flags.
            if (ovf_set)        epoch_ovf <= 1'b1;
            else if (clr_flags) epoch_ovf <= 1'b0;
            if (drop_set)       drop_flag <= 1'b1;
            else if (clr_flags) drop_flag <= 1'b0;
        end
    end

    count_evt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rec),
        .full      (full),
        .level     (fifo_level),
        .rd_valid  (evt.evt_valid),
        .rd_ready  (evt.evt_ready),
        .rd_data   (evt.evt_data)
    );

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor with a reference model and a record scoreboard queue.
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] count = '0;
    logic       clr_flags = 1'b0;
    logic       wrap_pulse;
    logic       err_pulse;
    logic [7:0] epoch;
    logic       epoch_ovf;
    logic       drop_flag;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    count_wrap_monitor_if #(.EPOCH_W(8)) evt_if ();

    count_wrap_monitor #(.EPOCH_W(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count      (count),
        .clr_flags  (clr_flags),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .epoch      (epoch),
        .epoch_ovf  (epoch_ovf),
        .drop_flag  (drop_flag),
        .fifo_level (fifo_level),
        .evt        (evt_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [12:0] q[$];
    logic [3:0]  m_prev;
    logic        m_vld;
    logic [7:0]  m_epoch;
    logic        m_ovf;
    logic        m_drop;
    logic        m_wp;
    logic        m_ep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_prev  = '0;
        m_vld   = 1'b0;
        m_epoch = '0;
        m_ovf   = 1'b0;
        m_drop  = 1'b0;
        m_wp    = 1'b0;
        m_ep    = 1'b0;
    endtask

    // One clock: drive inputs, pop/compare the head that will be consumed, predict, then check outputs.
    task automatic tick(input logic e, input logic [3:0] c, input logic rdy, input logic clr);
        logic        chk;
        logic        wrap;
        logic        err;
        logic [3:0]  exp_cnt;
        logic [7:0]  ep_new;
        logic [12:0] rec;
        logic [12:0] head;
        en = e;
        count = c;
        evt_if.evt_ready = rdy;
        clr_flags = clr;
        #1;
        if (rdy && q.size() > 0) begin
            head = q.pop_front();
            check("evt_data_head", 32'(evt_if.evt_data), 32'(head));
        end
        exp_cnt = m_prev - 4'd1;
        chk  = e && m_vld;
        wrap = chk && (m_prev == 4'd0) && (c == 4'd15);
        err  = chk && (c != exp_cnt);
        ep_new = wrap ? m_epoch + 8'd1 : m_epoch;
        rec = {err, ep_new, c};
        if (wrap || err) begin
            if (q.size() < 4) q.push_back(rec);
            else m_drop = 1'b1;
        end else if (clr) begin
            m_drop = 1'b0;
        end
        if (wrap && m_epoch == 8'hFF) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr && (wrap || err) && q.size() < 4) m_drop = 1'b0;
        m_epoch = ep_new;
        m_wp = wrap;
        m_ep = err;
        if (e) m_prev = c;
        m_vld = e;
        @(posedge clk);
        #1;
        check("wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
        check("err_pulse",  32'(err_pulse),  32'(m_ep));
        check("epoch",      32'(epoch),      32'(m_epoch));
        check("epoch_ovf",  32'(epoch_ovf),  32'(m_ovf));
        check("drop_flag",  32'(drop_flag),  32'(m_drop));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("evt_valid",  32'(evt_if.evt_valid), 32'(q.size() != 0));
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_evt_valid",  32'(evt_if.evt_valid), 32'd0);
        check("rst_epoch",      32'(epoch),            32'd0);
        check("rst_fifo_level", 32'(fifo_level),       32'd0);
        check("rst_evt_data",   32'(evt_if.evt_data),  32'd0);
        check("rst_pulses",     32'({wrap_pulse, err_pulse}), 32'd0);
        check("rst_flags",      32'({epoch_ovf, drop_flag}),  32'd0);
        model_clear();
        #3;
        rst = 1'b0;
    endtask

    int n_err;

    initial begin
        evt_if.evt_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("init_evt_valid",  32'(evt_if.evt_valid), 32'd0);
        check("init_epoch",      32'(epoch),            32'd0);
        check("init_fifo_level", 32'(fifo_level),       32'd0);
        check("init_evt_data",   32'(evt_if.evt_data),  32'd0);
        rst = 1'b0;

        // Free-running down count, consumer always ready: two wraps, no errors
        n_err = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 4'(15 - (i % 16)), 1'b1, 1'b0);
            if (err_pulse) n_err++;
        end
        check("run_epoch", 32'(epoch), 32'd2);
        check("run_no_err", 32'(n_err), 32'd0);

        // Hold at 7 for two edges -> one error record, epoch unchanged
        tick(1'b1, 4'd7, 1'b1, 1'b0);
        tick(1'b1, 4'd7, 1'b0, 1'b0);
        check("hold_err_pulse", 32'(err_pulse), 32'd1);
        check("hold_record", 32'(evt_if.evt_data), 32'({1'b1, 8'd2, 4'd7}));
        tick(1'b1, 4'd6, 1'b1, 1'b0);
        check("hold_err_once", 32'(err_pulse), 32'd0);
        check("hold_epoch", 32'(epoch), 32'd2);
        tick(1'b0, 4'd0, 1'b1, 1'b0);

        // Stalled consumer, six wraps into a depth-4 FIFO
        async_reset();
        for (int i = 0; i < 97; i++) tick(1'b1, 4'(15 - (i % 16)), 1'b0, 1'b0);
        check("stall_level", 32'(fifo_level), 32'd4);
        check("stall_drop", 32'(drop_flag), 32'd1);
        check("stall_head_epoch", 32'(evt_if.evt_data[11:4]), 32'd1);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        check("clr_drop", 32'(drop_flag), 32'd0);

        // Full FIFO, wrap coincident with a pop: accepted, level unchanged
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 4'd0, 1'b0, 1'b0);
        tick(1'b1, 4'd15, 1'b1, 1'b0);
        check("full_pop_level", 32'(fifo_level), 32'd4);
        check("full_pop_drop", 32'(drop_flag), 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 1'b1, 1'b0);
        check("drain_level", 32'(fifo_level), 32'd0);

        // 256 wraps roll the epoch over
        async_reset();
        for (int i = 0; i < 4097; i++) tick(1'b1, 4'(15 - (i % 16)), 1'b1, 1'b0);
        check("ovf_epoch", 32'(epoch), 32'd0);
        check("ovf_flag", 32'(epoch_ovf), 32'd1);
        tick(1'b0, 4'd0, 1'b1, 1'b1);
        check("clr_ovf", 32'(epoch_ovf), 32'd0);

        // Reset mid-stream with three queued events
        tick(1'b1, 4'd0, 1'b0, 1'b0);
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        tick(1'b1, 4'd15, 1'b0, 1'b0);
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        check("pre_rst_epoch", 32'(epoch), 32'd1);
        async_reset();
        tick(1'b1, 4'd9, 1'b1, 1'b0);
        check("post_rst_no_evt", 32'(evt_if.evt_valid), 32'd0);
        tick(1'b1, 4'd3, 1'b1, 1'b0);
        tick(1'b0, 4'd0, 1'b1, 1'b0);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter: EPOCH_W, 8, width of wrap-epoch counter.
REQ-002 Parameter: FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).
REQ-003 Port: clk  input  1  clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: en  input  1  monitoring enable.
REQ-006 Port: count  input  4  sampled output of the upstream 4-bit down counter.
REQ-007 Port: clr_flags  input  1  synchronous clear of sticky flags.
REQ-008 Port: wrap_pulse  output  1  one-cycle pulse per detected wrap 0->15.
REQ-009 Port: err_pulse  output  1  one-cycle pulse per sequence error.
REQ-010 Port: epoch  output  EPOCH_W  number of wraps since reset, modulo 2^EPOCH_W.
REQ-011 Port: epoch_ovf  output  1  sticky, epoch rolled over.
REQ-012 Port: drop_flag  output  1  sticky, event lost because FIFO was full.
REQ-013 Port: evt_valid  output  1  FIFO head record available.
REQ-014 Port: evt_ready  input  1  consumer accepts head record.
REQ-015 Port: evt_data  output  EPOCH_W+5  record {type[1], epoch[EPOCH_W], count[4]}.
REQ-016 Port: fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-017 Each edge with en=1 SHALL register count into prev_cnt and set prev_vld; en=0 SHALL clear prev_vld and suppress all detection.
REQ-018 First sample after reset or after en rising SHALL only establish prev_cnt; no check.
REQ-019 With prev_vld=1, expected = (prev_cnt - 1) mod 16; count == expected SHALL be a legal step.
REQ-020 prev_cnt=0 and count=15 SHALL be a wrap event: type 0, epoch increments by 1.
REQ-021 count != expected SHALL be an error event: type 1, epoch unchanged; includes a hold (count == prev_cnt) and an upstream reload to 15 from non-zero.
REQ-022 Event record SHALL carry the post-update epoch (wrap) or current epoch (error) and the offending count.
REQ-023 wrap_pulse/err_pulse SHALL be registered, asserted the cycle after the edge sampling the event, for exactly one cycle.
REQ-024 A pushed event SHALL raise evt_valid the cycle after the detecting edge (1-cycle latency) when FIFO was empty.
REQ-025 Pop SHALL occur on edge with evt_valid=1 and evt_ready=1; evt_data SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-026 Push when full without simultaneous pop SHALL drop the event and set drop_flag; push and pop in the same cycle when full SHALL accept the event, level unchanged.
REQ-027 Epoch increment from 2^EPOCH_W-1 SHALL wrap to 0 and set epoch_ovf.
REQ-028 clr_flags SHALL clear drop_flag and epoch_ovf; a set condition in the same cycle SHALL win.
REQ-029 evt_valid SHALL equal (fifo_level != 0); FIFO order strictly first-in first-out.

Reset
REQ-030 rst SHALL asynchronously force prev_cnt=0, prev_vld=0, epoch=0, epoch_ovf=0, drop_flag=0, wrap_pulse=0, err_pulse=0, FIFO empty (evt_valid=0, fifo_level=0), evt_data=0.
REQ-031 rst mid-operation SHALL discard all queued events; first post-reset sample follows REQ-018.

Structure
REQ-032 Shared package count_mon_pkg SHALL hold event-type encodings (EVT_WRAP=0, EVT_ERR=1), COUNT_W=4, and record-width function of EPOCH_W.
REQ-033 FIFO SHALL be a separate sub-module count_evt_fifo (parameterised width/depth, valid/ready read side, full/level outputs); detection and epoch logic stay in the top.

Verification
REQ-034 Free-running 15..0 sequence for 40 cycles, evt_ready=1 -> two wrap records with epoch 1 and 2, count field 15, no err_pulse.
REQ-035 Count held at 7 for two edges -> one error record {1, epoch, 7}, err_pulse one cycle, epoch unchanged.
REQ-036 evt_ready=0, six wraps with FIFO_DEPTH=4 -> fifo_level=4, drop_flag=1, head record epoch=1; then clr_flags -> drop_flag=0.
REQ-037 FIFO full, wrap event coincident with pop -> no drop, level stays 4, new record at tail.
REQ-038 EPOCH_W=8, 256 wraps -> epoch=0, epoch_ovf=1.
REQ-039 rst asserted mid-stream with 3 queued events -> evt_valid=0, epoch=0 immediately; first sample after release produces no event.
